// File: rtl/info_panel_scanner_pkg.sv
// info_panel_scanner_pkg: shared HUD glyph constants, label widths and scanner state
package info_panel_scanner_pkg;
  localparam int GLYPH_H = 24;
  localparam int DIGIT_W = 17;
  localparam logic [7:0] TRANSPARENT = 8'hE3;
  localparam logic [2:0] INFO_ROUND = 3'd0;
  localparam logic [2:0] INFO_TIME = 3'd1;
  localparam logic [2:0] INFO_BUFF = 3'd2;
  localparam logic [2:0] INFO_HP = 3'd3;
  localparam logic [2:0] INFO_SHIELD = 3'd4;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN, ST_DONE} scan_state_t;
  function automatic logic [7:0] label_width(input logic [2:0] t);
    return t == INFO_ROUND ? 8'd100 :
           (t == INFO_TIME || t == INFO_BUFF) ? 8'd72 :
           t == INFO_HP ? 8'd44 : 8'd93;
  endfunction
endpackage

// File: rtl/info_pixel_fifo.sv
// info_pixel_fifo: synchronous skid FIFO with occupancy count; head reads as zero when empty
module info_pixel_fifo #(
  parameter int W = 27,
  parameter int DEPTH = 4,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = empty ? '0 : mem[rd_ptr];
  always_ff @(posedge vga_clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/info_panel_scanner.sv
// info_panel_scanner: walks panel glyph coordinates into the reader and streams
// non-transparent pixels to the framebuffer writer under credit-based flow control.
module info_panel_scanner
  import info_panel_scanner_pkg::*;
#(
  parameter int READ_LAT = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] info_type,
  input  logic [4:0] num,
  input  logic [9:0] base_x,
  input  logic [8:0] base_y,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_x,
  output logic [4:0] rd_y,
  output logic [2:0] rd_info_type,
  output logic [4:0] rd_num,
  input  logic [7:0] rd_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [9:0] wr_x,
  output logic [8:0] wr_y,
  output logic [7:0] wr_data
);
  localparam int IW = $clog2(READ_LAT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = (IW > CW ? IW : CW) + 1;
  scan_state_t state, state_nx;
  logic [7:0] pw;
  logic [9:0] base_xr;
  logic [8:0] base_yr;
  logic [IW-1:0] inflight;
  logic [CW-1:0] fifo_count;
  logic [READ_LAT-1:0] tag_v;
  logic [7:0] tag_x [READ_LAT];
  logic [4:0] tag_y [READ_LAT];
  logic accept, issue, wrap_x, last, ret_valid, push, fifo_empty;
  logic [26:0] px_in;
  assign busy = state == ST_SCAN || state == ST_DRAIN;
  assign done = state == ST_DONE;
  assign accept = start && !busy;
  // Reads already in flight are counted as FIFO space so returns can never overflow it
  assign issue = state == ST_SCAN && OW'(fifo_count) + OW'(inflight) < OW'(FIFO_DEPTH);
  assign wrap_x = rd_x == pw - 8'd1;
  assign last = wrap_x && rd_y == 5'(GLYPH_H - 1);
  assign ret_valid = tag_v[READ_LAT-1];
  assign push = ret_valid && rd_data != TRANSPARENT;
  assign px_in = {base_xr + {2'b0, tag_x[READ_LAT-1]}, base_yr + {4'b0, tag_y[READ_LAT-1]}, rd_data};
  assign wr_valid = !fifo_empty;
  always_comb begin
    state_nx = state;
    state_nx = accept ? ST_SCAN :
               state == ST_SCAN && issue && last ? ST_DRAIN :
               state == ST_DRAIN && inflight == '0 && fifo_count == '0 ? ST_DONE :
               state == ST_DONE ? ST_IDLE : state;
  end
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      rd_x <= '0;
      rd_y <= '0;
      rd_info_type <= '0;
      rd_num <= '0;
      pw <= '0;
      base_xr <= '0;
      base_yr <= '0;
    end else if (accept) begin
      rd_x <= '0;
      rd_y <= '0;
      rd_info_type <= info_type;
      rd_num <= num > 5'd29 ? 5'd29 : num;
      pw <= label_width(info_type) + 8'(2 * DIGIT_W);
      base_xr <= base_x;
      base_yr <= base_y;
    end else if (issue) begin
      rd_x <= wrap_x ? '0 : rd_x + 8'd1;
      rd_y <= last ? '0 : rd_y + 5'(wrap_x);
    end
  // Tags ride alongside the reader pipeline so returning data knows its coordinate
  always_ff @(posedge vga_clk or posedge reset)
    if (reset) begin
      tag_v <= '0;
      inflight <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      tag_v[0] <= issue;
      tag_x[0] <= rd_x;
      tag_y[0] <= rd_y;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_x[i] <= tag_x[i-1];
        tag_y[i] <= tag_y[i-1];
      end
      inflight <= inflight + IW'(issue) - IW'(ret_valid);
    end
  info_pixel_fifo #(.W(27), .DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .vga_clk(vga_clk),
    .reset(reset),
    .push(push),
    .din(px_in),
    .pop(wr_ready),
    .dout({wr_x, wr_y, wr_data}),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_info_panel_scanner.sv
// tb_info_panel_scanner: table-driven and randomized scans checked against a panel-level pixel model
module tb_info_panel_scanner;
  logic vga_clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] info_type = '0;
  logic [4:0] num = '0;
  logic [9:0] base_x = '0;
  logic [8:0] base_y = '0;
  logic busy, done, wr_valid;
  logic [7:0] rd_x, wr_data;
  logic [4:0] rd_y, rd_num;
  logic [2:0] rd_info_type;
  logic [7:0] rd_data = '0;
  logic [7:0] rd_d1 = '0;
  logic wr_ready = 1'b0;
  logic [9:0] wr_x;
  logic [8:0] wr_y;

  info_panel_scanner dut (
    .vga_clk(vga_clk), .reset(reset), .start(start), .info_type(info_type), .num(num),
    .base_x(base_x), .base_y(base_y), .busy(busy), .done(done), .rd_x(rd_x), .rd_y(rd_y),
    .rd_info_type(rd_info_type), .rd_num(rd_num), .rd_data(rd_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    logic [2:0] it;
    logic [4:0] n;
    logic [9:0] bx;
    logic [8:0] by;
    int rm;
    int pm;
    int restart;
    int pw;
    logic [4:0] rn;
    int cnt;
  } vec_t;

  int errors = 0, checks = 0;
  int rmode = 0, pmode = 0;
  logic [2:0] exp_it = '0;
  logic [4:0] exp_num = '0;
  logic [26:0] got[$];
  logic [26:0] expq[$];
  logic [26:0] prev_w = '0;
  logic prev_stall = 1'b0;
  int got_base, done_base, stall_base, attr_base, fifo_base, busy_base;
  int done_cnt = 0, stall_bad = 0, attr_bad = 0, fifo_bad = 0, done_busy_bad = 0;

  function automatic logic [7:0] pix_of(int m, int x, int y);
    logic [7:0] b;
    b = 8'((x * 7 + y * 13) & 'h7F);
    return (m == 1 && x % 2 == 0) ? 8'hE3 : (m == 2 && (x + 3 * y) % 5 == 0) ? 8'hE3 : b;
  endfunction

  function automatic int label_w(logic [2:0] t);
    case (t)
      3'd0: return 100;
      3'd1, 3'd2: return 72;
      3'd3: return 44;
      default: return 93;
    endcase
  endfunction

  // Glyph reader: fixed two-cycle latency from coordinate to pixel
  always @(posedge vga_clk) begin
    rd_d1 <= pix_of(pmode, int'(rd_x), int'(rd_y));
    rd_data <= rd_d1;
  end

  // Writer side: drives backpressure, captures handshakes, watches invariants
  always @(negedge vga_clk) begin
    wr_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ($urandom_range(0, 9) < 3) : 1'b0;
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall && (!wr_valid || {wr_x, wr_y, wr_data} !== prev_w)) stall_bad++;
      if (wr_valid && wr_ready) got.push_back({wr_x, wr_y, wr_data});
      prev_stall = wr_valid && !wr_ready;
      prev_w = {wr_x, wr_y, wr_data};
      if (done) begin
        done_cnt++;
        if (busy) done_busy_bad++;
      end
      if (busy && (rd_info_type !== exp_it || rd_num !== exp_num)) attr_bad++;
      if (dut.u_fifo.count > 4) fifo_bad++;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_scan(logic [2:0] it, logic [4:0] n, logic [9:0] bx, logic [8:0] by, int rm, int pm);
    int pw;
    logic [7:0] p;
    pw = label_w(it) + 34;
    expq.delete();
    for (int y = 0; y < 24; y++)
      for (int x = 0; x < pw; x++) begin
        p = pix_of(pm, x, y);
        if (p != 8'hE3) expq.push_back({10'(int'(bx) + x), 9'(int'(by) + y), p});
      end
    exp_it = it;
    exp_num = n > 5'd29 ? 5'd29 : n;
    rmode = rm;
    pmode = pm;
    got_base = got.size();
    done_base = done_cnt;
    stall_base = stall_bad;
    attr_base = attr_bad;
    fifo_base = fifo_bad;
    busy_base = done_busy_bad;
    info_type = it;
    num = n;
    base_x = bx;
    base_y = by;
    start = 1'b1;
    @(negedge vga_clk);
    #1 start = 1'b0;
  endtask

  task automatic finish_scan(string tag, int exp_cnt, int restart, int nb_pw);
    int cyc, bad, n;
    cyc = 0;
    bad = -1;
    while (done_cnt == done_base && cyc < 40000) begin
      @(negedge vga_clk);
      #1 cyc++;
      if (cyc == restart) begin
        start = 1'b1;
        info_type = exp_it ^ 3'b101;
        num = 5'd1;
      end else start = 1'b0;
    end
    check({tag, " done_seen"}, 32'(done_cnt != done_base), 1);
    repeat (3) @(negedge vga_clk);
    #1;
    check({tag, " done_pulses"}, done_cnt - done_base, 1);
    check({tag, " busy_after"}, 32'(busy), 0);
    n = got.size() - got_base;
    check({tag, " writes"}, n, exp_cnt);
    check({tag, " model_writes"}, n, expq.size());
    for (int i = 0; i < n && i < expq.size(); i++)
      if (bad < 0 && got[got_base + i] !== expq[i]) bad = i;
    check({tag, " stream_first_bad_index"}, bad, -1);
    check({tag, " stall_unstable"}, stall_bad - stall_base, 0);
    check({tag, " attr_changed"}, attr_bad - attr_base, 0);
    check({tag, " fifo_over_depth"}, fifo_bad - fifo_base, 0);
    check({tag, " done_with_busy"}, done_busy_bad - busy_base, 0);
    if (nb_pw > 0) check({tag, " no_bubbles"}, 32'(cyc <= nb_pw * 24 + 8 && cyc >= nb_pw * 24), 1);
  endtask

  initial begin
    vec_t vecs[6];
    int cyc, pw, rm, pm;
    logic [2:0] it;
    logic [4:0] n;
    logic [9:0] bx;
    logic [8:0] by;
    vecs[0] = '{3'd3, 5'd7, 10'd100, 9'd50, 0, 0, 0, 78, 5'd7, 1872};
    vecs[1] = '{3'd0, 5'd31, 10'd0, 9'd0, 0, 0, 0, 134, 5'd29, 3216};
    vecs[2] = '{3'd1, 5'd5, 10'd20, 9'd10, 0, 1, 0, 106, 5'd5, 1272};
    vecs[3] = '{3'd2, 5'd30, 10'd300, 9'd200, 1, 0, 0, 0, 5'd29, 2544};
    vecs[4] = '{3'd7, 5'd12, 10'd1000, 9'd500, 0, 0, 0, 127, 5'd12, 3048};
    vecs[5] = '{3'd3, 5'd3, 10'd5, 9'd5, 0, 0, 10, 78, 5'd3, 1872};
    repeat (3) @(negedge vga_clk);
    #1;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst wr_valid", 32'(wr_valid), 0);
    check("rst rd_x", 32'(rd_x), 0);
    check("rst rd_y", 32'(rd_y), 0);
    check("rst rd_info_type", 32'(rd_info_type), 0);
    check("rst rd_num", 32'(rd_num), 0);
    check("rst wr_x", 32'(wr_x), 0);
    check("rst wr_y", 32'(wr_y), 0);
    check("rst wr_data", 32'(wr_data), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      start_scan(vecs[i].it, vecs[i].n, vecs[i].bx, vecs[i].by, vecs[i].rm, vecs[i].pm);
      check($sformatf("vec%0d rd_num", i), 32'(rd_num), 32'(vecs[i].rn));
      finish_scan($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].restart, vecs[i].pw);
      if (i == 0 && got.size() > got_base) begin
        check("vec0 first_xy", 32'(got[got_base][26:8]), 32'({10'd100, 9'd50}));
        check("vec0 last_xy", 32'(got[got.size() - 1][26:8]), 32'({10'd177, 9'd73}));
      end
    end
    start_scan(3'd3, 5'd9, 10'd40, 9'd30, 1, 0);
    cyc = 0;
    while (got.size() - got_base < 500 && cyc < 20000) begin
      @(negedge vga_clk);
      #1 cyc++;
    end
    check("midrst reached_500", 32'(got.size() - got_base >= 500), 1);
    rmode = 2;
    @(negedge vga_clk);
    #1 reset = 1'b1;
    @(negedge vga_clk);
    #1;
    check("midrst busy", 32'(busy), 0);
    check("midrst wr_valid", 32'(wr_valid), 0);
    check("midrst done", 32'(done), 0);
    reset = 1'b0;
    start_scan(3'd3, 5'd7, 10'd100, 9'd50, 0, 0);
    finish_scan("post_reset", 1872, 0, 78);
    for (int r = 0; r < 3; r++) begin
      it = 3'($urandom_range(0, 7));
      n = 5'($urandom_range(0, 31));
      bx = 10'($urandom);
      by = 9'($urandom);
      rm = $urandom_range(0, 1);
      pm = $urandom_range(0, 2);
      pw = label_w(it) + 34;
      start_scan(it, n, bx, by, rm, pm);
      finish_scan($sformatf("rand%0d", r), expq.size(), 0, rm == 0 ? pw : 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
